// File: rtl/branch_redirect_controller.sv
// Turns an EX-stage taken branch/jump into a registered redirect request to fetch,
// flushes the front pipeline registers, and counts accepted redirects.
module branch_redirect_controller #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EX_VALID,
  input  logic             BJ_SIG,
  input  logic [31:0]      BJ_TARGET,
  input  logic             MEM_BUSY,
  input  logic             FETCH_READY,
  input  logic             CLEAR_CNT,
  output logic             REDIRECT_VALID,
  output logic [31:0]      REDIRECT_PC,
  output logic             PC_SEL,
  output logic             FLUSH_IFID,
  output logic             FLUSH_IDEX,
  output logic             BUSY,
  output logic [CNT_W-1:0] TAKEN_COUNT
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

  state_t           state_q, state_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;
  logic [2:0]       drain_cnt_q, drain_cnt_d;
  logic             trigger;
  logic             accept;

  // A stalled EX instruction is not a trigger yet; it fires once MEM_BUSY drops.
  assign trigger = EX_VALID & BJ_SIG & ~MEM_BUSY;
  assign accept  = (state_q == IDLE) & trigger;

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    drain_cnt_d   = drain_cnt_q;
    taken_count_d = taken_count_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d       = REDIRECT;
          redirect_pc_d = BJ_TARGET;
        end
      end
      REDIRECT: begin
        if (FETCH_READY) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d     = DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q - 3'd1;
        if (drain_cnt_q <= 3'd1) begin
          state_d     = IDLE;
          drain_cnt_d = 3'd0;
        end
      end
      default: begin
        state_d     = IDLE;
        drain_cnt_d = 3'd0;
      end
    endcase

    // Clear wins over the old value, but a same-cycle accept still counts.
    if (CLEAR_CNT) begin
      taken_count_d = accept ? CNT_W'(1) : '0;
    end else if (accept) begin
      taken_count_d = taken_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q       <= IDLE;
      redirect_pc_q <= 32'd0;
      taken_count_q <= '0;
      drain_cnt_q   <= 3'd0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      taken_count_q <= taken_count_d;
      drain_cnt_q   <= drain_cnt_d;
    end
  end

  assign REDIRECT_VALID = (state_q == REDIRECT);
  assign PC_SEL         = REDIRECT_VALID & FETCH_READY;
  assign FLUSH_IFID     = (state_q == REDIRECT);
  assign FLUSH_IDEX     = (state_q == REDIRECT) | (state_q == DRAIN);
  assign BUSY           = (state_q != IDLE);
  assign REDIRECT_PC    = redirect_pc_q;
  assign TAKEN_COUNT    = taken_count_q;

endmodule

// File: tb/tb_branch_redirect_controller.sv
// Drives two controller instances (DRAIN_CYCLES=2/CNT_W=16 and DRAIN_CYCLES=0/CNT_W=4)
// with shared inputs and checks both against a behavioural model every cycle.
module tb_branch_redirect_controller;

  logic        CLK = 1'b0;
  logic        RESET, EX_VALID, BJ_SIG, MEM_BUSY, FETCH_READY, CLEAR_CNT;
  logic [31:0] BJ_TARGET;

  logic        rv [2];
  logic        ps [2];
  logic        ifid [2];
  logic        idex [2];
  logic        busy [2];
  logic [31:0] pc [2];
  logic [15:0] tc0;
  logic [3:0]  tc1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  branch_redirect_controller #(.DRAIN_CYCLES(2), .CNT_W(16)) dut0 (
    .CLK(CLK), .RESET(RESET), .EX_VALID(EX_VALID), .BJ_SIG(BJ_SIG), .BJ_TARGET(BJ_TARGET),
    .MEM_BUSY(MEM_BUSY), .FETCH_READY(FETCH_READY), .CLEAR_CNT(CLEAR_CNT),
    .REDIRECT_VALID(rv[0]), .REDIRECT_PC(pc[0]), .PC_SEL(ps[0]), .FLUSH_IFID(ifid[0]),
    .FLUSH_IDEX(idex[0]), .BUSY(busy[0]), .TAKEN_COUNT(tc0));

  branch_redirect_controller #(.DRAIN_CYCLES(0), .CNT_W(4)) dut1 (
    .CLK(CLK), .RESET(RESET), .EX_VALID(EX_VALID), .BJ_SIG(BJ_SIG), .BJ_TARGET(BJ_TARGET),
    .MEM_BUSY(MEM_BUSY), .FETCH_READY(FETCH_READY), .CLEAR_CNT(CLEAR_CNT),
    .REDIRECT_VALID(rv[1]), .REDIRECT_PC(pc[1]), .PC_SEL(ps[1]), .FLUSH_IFID(ifid[1]),
    .FLUSH_IDEX(idex[1]), .BUSY(busy[1]), .TAKEN_COUNT(tc1));

  // Model: a redirect is either outstanding, or some number of drain cycles remain, or neither.
  int          drain_p [2] = '{2, 0};
  int unsigned cnt_mod [2] = '{65536, 16};
  bit          m_redir [2];
  int          m_drain [2];
  logic [31:0] m_pc [2];
  int unsigned m_cnt [2];

  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (!RESET) begin
        m_redir[k] = 1'b0; m_drain[k] = 0; m_pc[k] = 32'd0; m_cnt[k] = 0;
      end else begin
        bit acc;
        acc = !m_redir[k] && m_drain[k] == 0 && EX_VALID && BJ_SIG && !MEM_BUSY;
        if (CLEAR_CNT)  m_cnt[k] = acc ? 1 : 0;
        else if (acc)   m_cnt[k] = (m_cnt[k] + 1) % cnt_mod[k];
        if (m_redir[k]) begin
          if (FETCH_READY) begin
            m_redir[k] = 1'b0;
            m_drain[k] = drain_p[k];
          end
        end else if (m_drain[k] > 0) begin
          m_drain[k] = m_drain[k] - 1;
        end else if (acc) begin
          m_redir[k] = 1'b1;
          m_pc[k]    = BJ_TARGET;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit fl;
        fl = m_redir[k] || (m_drain[k] > 0);
        chk($sformatf("m%0d_redirect_valid", k), 32'(rv[k]), 32'(m_redir[k]));
        chk($sformatf("m%0d_pc_sel", k), 32'(ps[k]), 32'(m_redir[k] && FETCH_READY));
        chk($sformatf("m%0d_flush_ifid", k), 32'(ifid[k]), 32'(m_redir[k]));
        chk($sformatf("m%0d_flush_idex", k), 32'(idex[k]), 32'(fl));
        chk($sformatf("m%0d_busy", k), 32'(busy[k]), 32'(fl));
        chk($sformatf("m%0d_redirect_pc", k), pc[k], m_pc[k]);
      end
      chk("m0_taken_count", 32'(tc0), 32'(m_cnt[0]));
      chk("m1_taken_count", 32'(tc1), 32'(m_cnt[1]));
    end
  end

  // Applies one cycle of inputs and returns just after the edge that consumes them.
  task automatic drive(logic rst, logic ex, logic bj, logic [31:0] tgt,
                       logic mem, logic fr, logic clr);
    RESET = rst; EX_VALID = ex; BJ_SIG = bj; BJ_TARGET = tgt;
    MEM_BUSY = mem; FETCH_READY = fr; CLEAR_CNT = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(logic fr);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, fr, 1'b0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b1);
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_pc", pc[0], 32'd0);
    chk("rst_cnt", 32'(tc0), 32'd0);

    // Basic redirect to 0x40
    drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    chk("basic_rv", 32'(rv[0]), 32'd1);
    chk("basic_pc", pc[0], 32'h40);
    chk("basic_pcsel", 32'(ps[0]), 32'd1);
    chk("basic_cnt", 32'(tc0), 32'd1);
    idle(1'b1);
    chk("basic_drain_rv", 32'(rv[0]), 32'd0);
    chk("basic_drain_idex1", 32'(idex[0]), 32'd1);
    idle(1'b1);
    chk("basic_drain_idex2", 32'(idex[0]), 32'd1);
    idle(1'b1);
    chk("basic_idle_idex", 32'(idex[0]), 32'd0);

    // Stall deferral
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h60, 1'b1, 1'b1, 1'b0);
      chk("stall_busy", 32'(busy[0]), 32'd0);
      chk("stall_cnt", 32'(tc0), 32'd1);
    end
    drive(1'b1, 1'b1, 1'b1, 32'h60, 1'b0, 1'b1, 1'b0);
    chk("stall_rv", 32'(rv[0]), 32'd1);
    chk("stall_cnt_after", 32'(tc0), 32'd2);
    repeat (3) idle(1'b1);
    chk("stall_back_idle", 32'(busy[0]), 32'd0);

    // Fetch backpressure with an extra BJ pulse while waiting
    drive(1'b1, 1'b1, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, (i == 2), 32'h9999, 1'b0, 1'b0, 1'b0);
      chk("bp_rv", 32'(rv[0]), 32'd1);
      chk("bp_pc", pc[0], 32'h1234);
      chk("bp_cnt", 32'(tc0), 32'd3);
    end
    idle(1'b1);
    chk("bp_released", 32'(rv[0]), 32'd0);
    chk("bp_cnt_final", 32'(tc0), 32'd3);
    repeat (2) idle(1'b1);

    // Back-to-back with no drain (instance 1)
    drive(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    chk("b2b_pc1", pc[1], 32'h100);
    chk("b2b_pcsel1", 32'(ps[1]), 32'd1);
    idle(1'b1);
    chk("b2b_gap_busy", 32'(busy[1]), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
    chk("b2b_rv2", 32'(rv[1]), 32'd1);
    chk("b2b_pc2", pc[1], 32'h200);
    chk("b2b_cnt", 32'(tc1), 32'd5);
    repeat (3) idle(1'b1);

    // Counter wrap and clear (4-bit instance)
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    chk("clr_cnt", 32'(tc1), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'(i * 4), 1'b0, 1'b1, 1'b0);
      idle(1'b1);
    end
    chk("wrap_cnt", 32'(tc1), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
    chk("clr_trig_cnt", 32'(tc1), 32'd1);
    repeat (4) idle(1'b1);

    // Reset in the middle of a redirect
    drive(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    chk("midrst_pc_before", pc[0], 32'h80);
    drive(1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 1'b1);
    chk("midrst_rv", 32'(rv[0]), 32'd0);
    chk("midrst_pcsel", 32'(ps[0]), 32'd0);
    chk("midrst_pc", pc[0], 32'd0);
    chk("midrst_idex", 32'(idex[0]), 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);

    // Randomised traffic; the per-cycle compare checks everything
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            $urandom, ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
            ($urandom_range(0, 15) == 0));
    end

    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
